fb_write_arbiter: RTL

- Shares the single frame-buffer write port (Avalon-MM style, waitrequest flow control) between the line rasterizer and the arc rasterizer pixel streams.
- Accepts pixels over valid/ready handshakes and arbitrates between the two sources round-robin.
- Converts (x,y) to a linear address, drops off-screen pixels, and holds each bus write until the slave accepts it.
- Provides an idle flag so the core control unit can hold shapedone until every pixel of a shape has reached memory.

---
 rtl/fb_write_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter that merges the line and arc pixel streams onto one
// frame-buffer write port, clipping off-screen pixels and counting traffic.
module fb_write_arbiter #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               l_valid,
  input  logic [X_W-1:0]     l_x,
  input  logic [Y_W-1:0]     l_y,
  input  logic [COLOR_W-1:0] l_color,
  output logic               l_ready,
  input  logic               a_valid,
  input  logic [X_W-1:0]     a_x,
  input  logic [Y_W-1:0]     a_y,
  input  logic [COLOR_W-1:0] a_color,
  output logic               a_ready,
  output logic [ADDR_W-1:0]  avm_address,
  output logic [COLOR_W-1:0] avm_writedata,
  output logic               avm_write,
  input  logic               avm_waitrequest,
  input  logic               clr_counts,
  output logic               idle,
  output logic [15:0]        pix_count,
  output logic [15:0]        clip_count
);

  typedef enum logic {SRC_LINE = 1'b0, SRC_ARC = 1'b1} src_t;
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_LINE = 2'd1, GNT_ARC = 2'd2} grant_t;

  // One extra bit so a limit equal to 2**X_W (or 2**Y_W) still compares correctly.
  localparam logic [X_W:0] X_LIM = (X_W+1)'(H_RES);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(V_RES);

  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    pixel_addr = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  function automatic logic off_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    off_screen = ({1'b0, x} >= X_LIM) || ({1'b0, y} >= Y_LIM);
  endfunction

  src_t               last_grant_r;
  grant_t             grant_s;
  logic               can_accept_s;
  logic               accept_s;
  logic               clipped_s;
  logic               write_done_s;
  logic [X_W-1:0]     sel_x_s;
  logic [Y_W-1:0]     sel_y_s;
  logic [COLOR_W-1:0] sel_color_s;
  logic [ADDR_W-1:0]  avm_address_r;
  logic [COLOR_W-1:0] avm_writedata_r;
  logic               avm_write_r;
  logic [15:0]        pix_count_r;
  logic [15:0]        clip_count_r;

  assign can_accept_s  = !avm_write_r || !avm_waitrequest;
  assign write_done_s  = avm_write_r && !avm_waitrequest;
  assign l_ready       = can_accept_s && (grant_s == GNT_LINE);
  assign a_ready       = can_accept_s && (grant_s == GNT_ARC);
  assign accept_s      = (l_valid && l_ready) || (a_valid && a_ready);
  assign clipped_s     = off_screen(sel_x_s, sel_y_s);
  assign idle          = !avm_write_r && !l_valid && !a_valid;
  assign avm_address   = avm_address_r;
  assign avm_writedata = avm_writedata_r;
  assign avm_write     = avm_write_r;
  assign pix_count     = pix_count_r;
  assign clip_count    = clip_count_r;

  // Grant decision: a tie goes to whichever source did not win last.
  always_comb begin
    grant_s = GNT_NONE;
    case ({l_valid, a_valid})
      2'b10:   grant_s = GNT_LINE;
      2'b01:   grant_s = GNT_ARC;
      2'b11:   grant_s = (last_grant_r == SRC_ARC) ? GNT_LINE : GNT_ARC;
      default: grant_s = GNT_NONE;
    endcase
  end

  // Pixel mux feeding the address/clip logic from the granted source.
  always_comb begin
    sel_x_s     = l_x;
    sel_y_s     = l_y;
    sel_color_s = l_color;
    if (grant_s == GNT_ARC) begin
      sel_x_s     = a_x;
      sel_y_s     = a_y;
      sel_color_s = a_color;
    end else begin
      sel_x_s     = l_x;
      sel_y_s     = l_y;
      sel_color_s = l_color;
    end
  end

  // Round-robin history, updated only when a pixel is actually taken.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      last_grant_r <= SRC_ARC;
    end else if (accept_s) begin
      last_grant_r <= (grant_s == GNT_ARC) ? SRC_ARC : SRC_LINE;
    end
  end

  // Bus write register: loads on an in-range accept, holds while stalled.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      avm_write_r     <= 1'b0;
      avm_address_r   <= '0;
      avm_writedata_r <= '0;
    end else if (accept_s) begin
      if (clipped_s) begin
        avm_write_r <= 1'b0;
      end else begin
        avm_write_r     <= 1'b1;
        avm_address_r   <= pixel_addr(sel_x_s, sel_y_s);
        avm_writedata_r <= sel_color_s;
      end
    end else if (write_done_s) begin
      avm_write_r <= 1'b0;
    end
  end

  // Traffic counters; a clear takes priority over a coincident increment.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pix_count_r  <= 16'd0;
      clip_count_r <= 16'd0;
    end else if (clr_counts) begin
      pix_count_r  <= 16'd0;
      clip_count_r <= 16'd0;
    end else begin
      if (write_done_s) begin
        pix_count_r <= pix_count_r + 16'd1;
      end
      if (accept_s && clipped_s) begin
        clip_count_r <= clip_count_r + 16'd1;
      end
    end
  end

endmodule
